psum_accum_sfp: RTL and testbench
=================================

# psum_accum_sfp

Parametrised accumulation and special-function stage for the multichannel systolic core. It sits between the array's psum output and the final-output path. Across all kernel positions (kij) and all input-channel tiles (ic/row), it accumulates column psum vectors into an internal on-chip buffer indexed by output pixel (onij). It then drains the finished vectors with optional ReLU over a valid/ready handshake. It replaces host-sequenced read-modify-write psum SRAM traffic with a self-counting state machine.

## Interface
- psum_bw, 16, signed width of each column psum and of each output lane
- col, 8, number of columns (lanes per vector)
- len_onij, 16, output pixels per pass (buffer depth)
- len_kij, 9, kernel positions per tile
- n_tile, 2, input-channel tiles (ic/row); passes per job = len_kij*n_tile
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle job request, honoured only in IDLE
- relu_en  input  1  sampled at accepted start, held for the job
- in_valid  input  1  in_psum beat valid
- in_ready  output  1  high in ACC only
- in_psum  input  col*psum_bw  column psums, lane c at bits [c*psum_bw +: psum_bw]
- o_valid  output  1  sfp_out valid (DRAIN)
- out_ready  input  1  downstream accepts sfp_out
- sfp_out  output  col*psum_bw  accumulated (optionally ReLU'd) vector for pixel out_cnt
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after last output accepted

## Operation
- States: IDLE, ACC, DRAIN. Registers: buf[len_onij][col], onij_cnt, pass_cnt, out_cnt, relu_q.
- IDLE with start=1: relu_q<=relu_en, onij_cnt=pass_cnt=0, state goes to ACC. When not in IDLE, start is ignored.
- ACC: each handshake (in_valid&in_ready) updates buf[onij_cnt].
  - When pass_cnt==0, the buffer entry is overwritten with in_psum.
  - Otherwise the buffer entry becomes sat(buf+in_psum) per lane.
  - onij_cnt increments and wraps at len_onij-1 to 0. On wrap, pass_cnt increments.
  - The handshake carrying onij_cnt==len_onij-1 and pass_cnt==len_kij*n_tile-1 moves the state to DRAIN, with out_cnt=0.
- Saturation: signed add in psum_bw+1 bits, clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- DRAIN:
  - sfp_out lane = relu_q ? max(buf lane,0) : buf lane, taken from buf[out_cnt]. The path is combinational from registers.
  - A handshake (o_valid&out_ready) increments out_cnt.
  - The handshake at out_cnt==len_onij-1 moves the state to IDLE and sets done=1 for the next cycle.
- Buffer contents are not cleared between jobs, because the first pass overwrites them.
- in_valid outside ACC has no effect. out_ready outside DRAIN has no effect.

## Timing
- Reset values: in_ready=0, o_valid=0, busy=0, done=0, sfp_out=0. State is IDLE, all counters are 0, and buf is all 0.
- Reset asserted mid-job aborts immediately and asynchronously. A job needs a new start after reset release.
- start accepted at edge t: busy and in_ready go high in cycle t+1.
- Throughput is one beat per cycle in both ACC and DRAIN. Stalls are controlled only by in_valid and out_ready.
- Last input beat accepted at edge t: in_ready=0 and o_valid=1 from cycle t+1. sfp_out is then buf[0] including the final accumulation (zero-bubble turnaround).
- Last output accepted at edge t: busy=0, o_valid=0 and done=1 in cycle t+1. done=0 in cycle t+2.
- Minimum job length is 1 + len_onij*len_kij*n_tile + len_onij cycles from start to done.
- While o_valid=1 and out_ready=0, sfp_out is held stable.

## Test plan
- Basic accumulate: defaults, every beat has all lanes = +1, relu_en=0, continuous valid/ready.
  - Required: 16 outputs with every lane = 18.
  - Required: done occurs 1+288+16 cycles after start.
- Saturation and ReLU: lane 0 = +20000 and lane 1 = -20000 every beat.
  - relu_en=0 requires +32767 and -32768.
  - relu_en=1 requires +32767 and 0.
- Backpressure: random in_valid and out_ready at 50%, with beat value = pass_cnt*16+onij.
  - Required: output pixel n equals sum over p of (16p+n), i.e. 2448+18n.
  - Required: no loss or duplication, and sfp_out stable during stalls.
- Overwrite on new job: run job A (all +5), then job B (all -1), relu_en=0.
  - Required: job B outputs are -18 with no residue from A.
- Reset mid-ACC: assert reset after 100 beats.
  - Required: outputs return to reset values immediately, and start while busy is ignored.
  - Required: a subsequent full job gives correct sums.
- Ignored inputs: pulse start during ACC and DRAIN, and drive in_valid during IDLE and DRAIN.
  - Required: no change to counters, buffer or outputs.

Source files
------------

// File: rtl/psum_accum_sfp.sv
// psum_accum_sfp
// Accumulates column psum vectors from the systolic array into an on-chip
// buffer indexed by output pixel. This covers every kernel position and every
// input-channel tile. The finished vectors are then drained with optional ReLU.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   start      one-cycle job request (IDLE only)
//   relu_en    ReLU select, captured with start
//   in_valid   in_psum beat valid
//   in_ready   beat accepted when high (ACC only)
//   in_psum    col lanes of psum_bw bits, lane c at [c*psum_bw +: psum_bw]
//   o_valid    sfp_out valid (DRAIN only)
//   out_ready  downstream accepts sfp_out
//   sfp_out    accumulated vector for pixel out_cnt, optionally ReLU'd
//   busy       job in progress
//   done       one-cycle pulse after the last output is accepted
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// ACC   | accepting beats; first pass overwrites, later passes add with saturation
// DRAIN | presenting buf[out_cnt] until every pixel has been accepted
module psum_accum_sfp #(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int len_onij = 16,
  parameter int len_kij  = 9,
  parameter int n_tile   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*psum_bw-1:0] in_psum,
  output logic                   o_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] sfp_out,
  output logic                   busy,
  output logic                   done
);

  localparam int PASSES = len_kij * n_tile;
  localparam int ONIJ_W = (len_onij > 1) ? $clog2(len_onij) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [ONIJ_W-1:0] ONIJ_LAST = ONIJ_W'(len_onij - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  state_t state_q, state_d;

  logic [col*psum_bw-1:0] psum_buf [len_onij];
  logic [ONIJ_W-1:0]      onij_cnt;
  logic [ONIJ_W-1:0]      out_cnt;
  logic [PASS_W-1:0]      pass_cnt;
  logic                   relu_q;
  logic                   done_q;

  logic                   in_fire;
  logic                   out_fire;
  logic                   onij_wrap;
  logic [col*psum_bw-1:0] acc_vec;
  logic [col*psum_bw-1:0] wr_old;
  logic [col*psum_bw-1:0] rd_vec;
  logic [psum_bw-1:0]     lane;

  // Add in psum_bw+1 bits. An overflow shows up as disagreement between the
  // top two bits, and the extra bit gives the true sign for the clamp.
  function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1])
      return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    return s[psum_bw-1:0];
  endfunction

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = o_valid & out_ready;
  assign onij_wrap = (onij_cnt == ONIJ_LAST);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    o_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_fire && onij_wrap && (pass_cnt == PASS_LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        o_valid = 1'b1;
        if (out_fire && (out_cnt == ONIJ_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_vec = '0;
    wr_old  = psum_buf[onij_cnt];
    for (int c = 0; c < col; c++) begin
      acc_vec[c*psum_bw +: psum_bw] = (pass_cnt == '0) ? in_psum[c*psum_bw +: psum_bw]
          : sat_add(wr_old[c*psum_bw +: psum_bw], in_psum[c*psum_bw +: psum_bw]);
    end
  end

  // Outputs are forced to zero outside DRAIN, so stale buffer contents never leak.
  always_comb begin
    sfp_out = '0;
    lane    = '0;
    rd_vec  = psum_buf[out_cnt];
    if (state_q == DRAIN) begin
      for (int c = 0; c < col; c++) begin
        lane = rd_vec[c*psum_bw +: psum_bw];
        sfp_out[c*psum_bw +: psum_bw] = (relu_q && lane[psum_bw-1]) ? '0 : lane;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      onij_cnt <= '0;
      pass_cnt <= '0;
      out_cnt  <= '0;
      relu_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < len_onij; i++) psum_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            relu_q   <= relu_en;
            onij_cnt <= '0;
            pass_cnt <= '0;
          end
        end
        ACC: begin
          if (in_fire) begin
            psum_buf[onij_cnt] <= acc_vec;
            onij_cnt <= onij_wrap ? '0 : onij_cnt + 1'b1;
            if (onij_wrap) begin
              pass_cnt <= (pass_cnt == PASS_LAST) ? '0 : pass_cnt + 1'b1;
              if (pass_cnt == PASS_LAST) out_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            out_cnt <= (out_cnt == ONIJ_LAST) ? '0 : out_cnt + 1'b1;
            if (out_cnt == ONIJ_LAST) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_sfp.sv
`timescale 1ns/1ps
module tb_psum_accum_sfp;

  localparam int BW     = 16;
  localparam int COL    = 8;
  localparam int ONIJ   = 16;
  localparam int KIJ    = 9;
  localparam int NT     = 2;
  localparam int PASSES = KIJ * NT;
  localparam int BEATS  = ONIJ * PASSES;

  typedef logic [COL*BW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic relu_en = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  vec_t in_psum = '0;
  logic o_valid;
  logic out_ready = 1'b0;
  vec_t sfp_out;
  logic busy;
  logic done;

  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   start_cyc = 0;
  logic rnd_ready = 1'b0;
  vec_t exp_q[$];
  logic prev_stall = 1'b0;
  vec_t prev_out = '0;

  psum_accum_sfp #(.psum_bw(BW), .col(COL), .len_onij(ONIJ), .len_kij(KIJ), .n_tile(NT)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .o_valid(o_valid), .out_ready(out_ready), .sfp_out(sfp_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t fill(input int v);
    vec_t r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(v);
    return r;
  endfunction

  // kind 0: every lane = val; kind 1: lane0 +20000, lane1 -20000; kind 2: 16*pass+onij
  function automatic vec_t beat(input int kind, input int val, input int p, input int n);
    vec_t r;
    r = '0;
    case (kind)
      0: r = fill(val);
      1: begin
        r[0 +: BW]  = BW'(20000);
        r[BW +: BW] = BW'(-20000);
      end
      default: r = fill(p * 16 + n);
    endcase
    return r;
  endfunction

  function automatic vec_t expv(input int kind, input int val, input logic relu, input int n);
    vec_t r;
    int   v;
    r = '0;
    case (kind)
      0: begin
        v = 18 * val;
        if (relu && v < 0) v = 0;
        r = fill(v);
      end
      1: begin
        r[0 +: BW]  = BW'(32767);
        r[BW +: BW] = relu ? BW'(0) : BW'(-32768);
      end
      default: r = fill(2448 + 18 * n);
    endcase
    return r;
  endfunction

  // Scoreboard monitor: compares every accepted output and checks hold during stalls.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_valid) chk("stall_hold", sfp_out, prev_out);
      if (o_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", sfp_out, 'x);
        else chk("out_pixel", sfp_out, exp_q.pop_front());
      end
      prev_stall = o_valid && !out_ready;
      prev_out   = sfp_out;
    end
  end

  task automatic do_start(input logic relu, input int kind, input int val);
    for (int n = 0; n < ONIJ; n++) exp_q.push_back(expv(kind, val, relu, n));
    start   = 1'b1;
    relu_en = relu;
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc_cnt;
    chk("busy_after_start", vec_t'(busy), vec_t'(1));
    chk("in_ready_after_start", vec_t'(in_ready), vec_t'(1));
  endtask

  task automatic send_beats(input int kind, input int val, input logic rnd,
                            input int nbeats, input logic start_noise);
    logic hs;
    int   g;
    for (int k = 0; k < nbeats; k++) begin
      in_psum = beat(kind, val, k / ONIJ, k % ONIJ);
      g = 0;
      hs = 1'b0;
      while (!hs && g < 1000) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start    = start_noise && (k % 7 == 3);
        @(negedge clk);
        hs = in_valid && in_ready;
        @(posedge clk); #1;
        g++;
      end
      if (!hs) begin
        chk("beat_timeout", vec_t'(0), vec_t'(1));
        k = nbeats;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done(input logic check_lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!done && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", vec_t'(done), vec_t'(1));
    chk("busy_at_done", vec_t'(busy), vec_t'(0));
    chk("o_valid_at_done", vec_t'(o_valid), vec_t'(0));
    if (check_lat)
      chk("start_to_done_cycles", vec_t'(cyc_cnt - start_cyc + 1), vec_t'(1 + BEATS + ONIJ));
    @(negedge clk);
    chk("done_one_cycle", vec_t'(done), vec_t'(0));
    chk("all_outputs_drained", vec_t'(exp_q.size()), vec_t'(0));
    @(posedge clk); #1;
  endtask

  task automatic idle_quiet(input string name);
    chk({name, "_in_ready"}, vec_t'(in_ready), vec_t'(0));
    chk({name, "_o_valid"}, vec_t'(o_valid), vec_t'(0));
    chk({name, "_busy"}, vec_t'(busy), vec_t'(0));
    chk({name, "_done"}, vec_t'(done), vec_t'(0));
    chk({name, "_sfp_out"}, sfp_out, vec_t'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    idle_quiet("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // basic accumulate with start-to-done latency
    do_start(1'b0, 0, 1);
    send_beats(0, 1, 1'b0, BEATS, 1'b0);
    wait_done(1'b1);

    // saturation without and with ReLU
    do_start(1'b0, 1, 0);
    send_beats(1, 0, 1'b0, BEATS, 1'b0);
    wait_done(1'b0);
    do_start(1'b1, 1, 0);
    send_beats(1, 0, 1'b0, BEATS, 1'b0);
    wait_done(1'b0);

    // random backpressure on both sides
    rnd_ready = 1'b1;
    do_start(1'b0, 2, 0);
    send_beats(2, 0, 1'b1, BEATS, 1'b0);
    wait_done(1'b0);
    rnd_ready = 1'b0;
    @(posedge clk); #1;

    // job B must fully overwrite job A
    do_start(1'b0, 0, 5);
    send_beats(0, 5, 1'b0, BEATS, 1'b0);
    wait_done(1'b0);
    do_start(1'b0, 0, -1);
    send_beats(0, -1, 1'b0, BEATS, 1'b0);
    wait_done(1'b0);

    // asynchronous reset in the middle of ACC
    do_start(1'b0, 0, 3);
    send_beats(0, 3, 1'b0, 100, 1'b0);
    #3 reset = 1'b1;
    #1;
    idle_quiet("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    idle_quiet("after_reset");
    do_start(1'b0, 0, 2);
    send_beats(0, 2, 1'b0, BEATS, 1'b0);
    wait_done(1'b0);

    // start pulses during ACC, start and in_valid noise during DRAIN and IDLE
    do_start(1'b0, 0, 7);
    send_beats(0, 7, 1'b0, BEATS, 1'b1);
    in_psum = fill(1234);
    for (int i = 0; i < 6; i++) begin
      start    = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      chk("drain_in_ready", vec_t'(in_ready), vec_t'(0));
      @(posedge clk); #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    wait_done(1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_quiet("idle_noise");
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
